tinyrv1_run_ctrl: RTL and testbench

Run-control sequencer for the tinyrv1 core: gates core advance via a per-cycle enable, and supports free-run, N-instruction stepping, a single PC breakpoint and host halt. Also sequences a register-file dump over the core's debug read port (x1..x31). Sits between the host/debug command interface and the core's debug_pc / debug_reg_addr / debug_reg_data ports. The core retires one instruction per cycle while core_en=1.

---
 rtl/tinyrv1_run_ctrl_if.sv | 32 +++
 rtl/tinyrv1_run_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_tinyrv1_run_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinyrv1_run_ctrl_if.sv
// Host command channel for the tinyrv1 run-control sequencer.
//   cmd_valid : host has a command on cmd_op/cmd_arg
//   cmd_ready : sequencer can accept a command this cycle
//   cmd_op    : 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 SET_BKPT, 5 CLR_BKPT, 6 DUMP, 7 CLR_CNT
//   cmd_arg   : step count (low bits) or breakpoint address
//   cmd_err   : one-cycle pulse, previous accepted command was ignored
// master = host side, slave = sequencer side.
interface tinyrv1_run_ctrl_if #(
  parameter int XLEN = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [XLEN-1:0] cmd_arg;
  logic            cmd_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready,
    output cmd_err
  );
endinterface

// File: rtl/tinyrv1_run_ctrl.sv
// Run-control sequencer for the tinyrv1 core. Gates core advance with a
// per-cycle enable (free-run, N-step, single PC breakpoint, host halt) and
// walks the register file debug port to stream x1..x31 to the host.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   cmd_if         host command channel (slave side)
//   core_en_o      core advance enable (combinational)
//   core_pc_i      core current PC
//   rf_addr_o      register-file debug read address
//   rf_data_i      register-file debug read data (combinational from rf_addr_o)
//   halted_o       1 while halted
//   halt_cause_o   0 RESET, 1 HOST, 2 STEP_DONE, 3 BKPT
//   retired_cnt_o  saturating count of core_en cycles
//   dump_valid_o   dump beat valid
//   dump_addr_o    register index of dump beat
//   dump_data_o    register value of dump beat
//
// state   | meaning
// HALTED  | core stopped, all commands legal
// RUN     | core free-running until HALT or breakpoint
// STEP    | core runs until step counter expires, HALT or breakpoint
// DUMP    | streaming x1..x31, commands blocked
module tinyrv1_run_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tinyrv1_run_ctrl_if.slave    cmd_if,
  output logic                 core_en_o,
  input  logic [XLEN-1:0]      core_pc_i,
  output logic [4:0]           rf_addr_o,
  input  logic [XLEN-1:0]      rf_data_i,
  output logic                 halted_o,
  output logic [1:0]           halt_cause_o,
  output logic [CNT_W-1:0]     retired_cnt_o,
  output logic                 dump_valid_o,
  output logic [4:0]           dump_addr_o,
  output logic [XLEN-1:0]      dump_data_o
);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_RUN      = 3'd1;
  localparam logic [2:0] OP_STEP     = 3'd2;
  localparam logic [2:0] OP_HALT     = 3'd3;
  localparam logic [2:0] OP_SET_BKPT = 3'd4;
  localparam logic [2:0] OP_CLR_BKPT = 3'd5;
  localparam logic [2:0] OP_DUMP     = 3'd6;
  localparam logic [2:0] OP_CLR_CNT  = 3'd7;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_HOST  = 2'd1;
  localparam logic [1:0] CAUSE_STEP  = 2'd2;
  localparam logic [1:0] CAUSE_BKPT  = 2'd3;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DUMP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              resume_skip_q, resume_skip_d;
  logic              bkpt_valid_q, bkpt_valid_d;
  logic [XLEN-1:0]   bkpt_addr_q, bkpt_addr_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic              dump_valid_q, dump_valid_d;
  logic [4:0]        dump_addr_q, dump_addr_d;
  logic [XLEN-1:0]   dump_data_q, dump_data_d;
  logic              cmd_err_q, cmd_err_d;

  logic              cmd_ready;
  logic              core_en;
  logic              busy;
  logic              cmd_fire;
  logic              halt_cmd;
  logic              bkpt_match;
  logic              step_last;
  logic [CNT_W-1:0]  step_arg;

  assign busy       = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cmd_fire   = cmd_if.cmd_valid && cmd_ready;
  assign halt_cmd   = cmd_fire && (cmd_if.cmd_op == OP_HALT);
  // resume_skip masks the breakpoint for the first enabled cycle so that a
  // resume from a breakpoint executes the matching instruction once.
  assign bkpt_match = bkpt_valid_q && (core_pc_i == bkpt_addr_q) && !resume_skip_q;
  assign step_last  = (state_q == ST_STEP) && core_en && (step_cnt_q == CNT_W'(1));
  assign step_arg   = cmd_if.cmd_arg[CNT_W-1:0];

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_HALTED: begin
        if (cmd_fire) begin
          case (cmd_if.cmd_op)
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: state_d = ST_STEP;
            OP_DUMP: state_d = ST_DUMP;
            default: state_d = ST_HALTED;
          endcase
        end
      end
      ST_RUN, ST_STEP: begin
        // Priority: breakpoint over host halt over step completion.
        if (bkpt_match) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BKPT;
        end else if (halt_cmd) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end else if (step_last) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
        end
      end
      ST_DUMP: begin
        // rf_addr wraps to 0 after x31 was read; beat 31 is shown this cycle.
        if (rf_addr_q == 5'd0) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // outputs
  always_comb begin
    cmd_ready = (state_q != ST_DUMP);
    core_en   = busy && !bkpt_match;
    halted_o  = (state_q == ST_HALTED);
  end

  // datapath next values
  always_comb begin
    step_cnt_d    = step_cnt_q;
    retired_d     = retired_q;
    resume_skip_d = resume_skip_q;
    bkpt_valid_d  = bkpt_valid_q;
    bkpt_addr_d   = bkpt_addr_q;
    rf_addr_d     = rf_addr_q;
    dump_valid_d  = 1'b0;
    dump_addr_d   = dump_addr_q;
    dump_data_d   = dump_data_q;
    cmd_err_d     = 1'b0;

    if ((state_q == ST_HALTED) && cmd_fire) begin
      case (cmd_if.cmd_op)
        OP_RUN: resume_skip_d = 1'b1;
        OP_STEP: begin
          resume_skip_d = 1'b1;
          step_cnt_d    = (step_arg == '0) ? CNT_W'(1) : step_arg;
        end
        OP_SET_BKPT: begin
          bkpt_addr_d  = cmd_if.cmd_arg;
          bkpt_valid_d = 1'b1;
        end
        OP_CLR_BKPT: bkpt_valid_d = 1'b0;
        OP_DUMP:     rf_addr_d    = 5'd1;
        default: ;
      endcase
    end

    if (busy && cmd_fire && (cmd_if.cmd_op != OP_HALT)) begin
      cmd_err_d = 1'b1;
    end

    if (core_en) begin
      resume_skip_d = 1'b0;
      if (state_q == ST_STEP) begin
        step_cnt_d = step_cnt_q - CNT_W'(1);
      end
    end

    if ((state_q == ST_HALTED) && cmd_fire && (cmd_if.cmd_op == OP_CLR_CNT)) begin
      retired_d = '0;
    end else if (core_en && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end

    if ((state_q == ST_DUMP) && (rf_addr_q != 5'd0)) begin
      dump_valid_d = 1'b1;
      dump_addr_d  = rf_addr_q;
      dump_data_d  = rf_data_i;
      rf_addr_d    = (rf_addr_q == 5'd31) ? 5'd0 : rf_addr_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_q       <= CAUSE_RESET;
      step_cnt_q    <= '0;
      retired_q     <= '0;
      resume_skip_q <= 1'b0;
      bkpt_valid_q  <= 1'b0;
      bkpt_addr_q   <= '0;
      rf_addr_q     <= 5'd0;
      dump_valid_q  <= 1'b0;
      dump_addr_q   <= 5'd0;
      dump_data_q   <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      cause_q       <= cause_d;
      step_cnt_q    <= step_cnt_d;
      retired_q     <= retired_d;
      resume_skip_q <= resume_skip_d;
      bkpt_valid_q  <= bkpt_valid_d;
      bkpt_addr_q   <= bkpt_addr_d;
      rf_addr_q     <= rf_addr_d;
      dump_valid_q  <= dump_valid_d;
      dump_addr_q   <= dump_addr_d;
      dump_data_q   <= dump_data_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign cmd_if.cmd_ready = cmd_ready;
  assign cmd_if.cmd_err   = cmd_err_q;
  assign core_en_o        = core_en;
  assign rf_addr_o        = rf_addr_q;
  assign halt_cause_o     = cause_q;
  assign retired_cnt_o    = retired_q;
  assign dump_valid_o     = dump_valid_q;
  assign dump_addr_o      = dump_addr_q;
  assign dump_data_o      = dump_data_q;

endmodule

// File: tb/tb_tinyrv1_run_ctrl.sv
// Directed bench for tinyrv1_run_ctrl with a simple core/register-file model
// and a queue of expected dump beats.
module tb_tinyrv1_run_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [2:0] OP_RUN      = 3'd1;
  localparam logic [2:0] OP_STEP     = 3'd2;
  localparam logic [2:0] OP_HALT     = 3'd3;
  localparam logic [2:0] OP_SET_BKPT = 3'd4;
  localparam logic [2:0] OP_DUMP     = 3'd6;
  localparam logic [2:0] OP_CLR_CNT  = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tinyrv1_run_ctrl_if #(.XLEN(XLEN)) cmd_if ();

  logic              core_en;
  logic [XLEN-1:0]   core_pc = '0;
  logic [4:0]        rf_addr;
  logic [XLEN-1:0]   rf_data;
  logic              halted;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  retired_cnt;
  logic              dump_valid;
  logic [4:0]        dump_addr;
  logic [XLEN-1:0]   dump_data;

  logic [XLEN-1:0]   regs [32];
  logic              pc_load = 1'b0;
  logic [XLEN-1:0]   pc_load_val = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } beat_t;
  beat_t exp_q[$];

  tinyrv1_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_if        (cmd_if.slave),
    .core_en_o     (core_en),
    .core_pc_i     (core_pc),
    .rf_addr_o     (rf_addr),
    .rf_data_i     (rf_data),
    .halted_o      (halted),
    .halt_cause_o  (halt_cause),
    .retired_cnt_o (retired_cnt),
    .dump_valid_o  (dump_valid),
    .dump_addr_o   (dump_addr),
    .dump_data_o   (dump_data)
  );

  // Core model: one instruction (PC += 4) per enabled cycle.
  always @(posedge clk) begin
    if (pc_load) core_pc <= pc_load_val;
    else if (core_en === 1'b1) core_pc <= core_pc + 32'd4;
  end

  always_comb rf_data = regs[rf_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    check("cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_arg   = '0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    tick();
    pc_load     = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (halted) break;
      tick();
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int beats;
    int ready_bad;
    beat_t e;
    logic [31:0] b;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_arg   = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | 32'(i);
    regs[0]  = 32'h0;
    regs[5]  = 32'hDEAD_BEEF;
    regs[31] = 32'h1234_5678;

    // reset values
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_core_en", {31'd0, core_en}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rst_cause", {30'd0, halt_cause}, 32'd0);
    check("rst_retired", {16'd0, retired_cnt}, 32'd0);
    check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_if.cmd_err}, 32'd0);
    rst = 1'b1;
    load_pc(32'h0);

    // RUN 10 cycles then HALT
    send_cmd(OP_RUN, 32'h0);
    check("run_core_en", {31'd0, core_en}, 32'd1);
    check("run_not_halted", {31'd0, halted}, 32'd0);
    repeat (9) tick();
    send_cmd(OP_HALT, 32'h0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_cause", {30'd0, halt_cause}, 32'd1);
    check("halt_retired", {16'd0, retired_cnt}, 32'd10);
    check("halt_core_en", {31'd0, core_en}, 32'd0);
    check("halt_pc", core_pc, 32'h28);

    // STEP 5
    send_cmd(OP_STEP, 32'd5);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (core_en) n++;
      tick();
    end
    check("step5_count", 32'(n), 32'd5);
    check("step5_cause", {30'd0, halt_cause}, 32'd2);
    check("step5_retired", {16'd0, retired_cnt}, 32'd15);

    // STEP 0 behaves as STEP 1
    send_cmd(OP_STEP, 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (core_en) n++;
      tick();
    end
    check("step0_count", 32'(n), 32'd1);
    check("step0_retired", {16'd0, retired_cnt}, 32'd16);
    check("step0_pc", core_pc, 32'h40);

    send_cmd(OP_CLR_CNT, 32'h0);
    check("clr_cnt", {16'd0, retired_cnt}, 32'd0);

    // Breakpoint at 0x10, run from 0
    send_cmd(OP_SET_BKPT, 32'h10);
    load_pc(32'h0);
    send_cmd(OP_RUN, 32'h0);
    wait_halted("bkpt_halt", 20);
    check("bkpt_pc", core_pc, 32'h10);
    check("bkpt_cause", {30'd0, halt_cause}, 32'd3);
    check("bkpt_retired", {16'd0, retired_cnt}, 32'd4);

    // Resume one step from the breakpoint
    send_cmd(OP_STEP, 32'd1);
    wait_halted("resume_halt", 10);
    check("resume_pc", core_pc, 32'h14);
    check("resume_cause", {30'd0, halt_cause}, 32'd2);
    check("resume_retired", {16'd0, retired_cnt}, 32'd5);

    // Register dump
    for (int i = 1; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: regs[i]});
    send_cmd(OP_DUMP, 32'h0);
    check("dump_ready_low", {31'd0, cmd_if.cmd_ready}, 32'd0);
    check("dump_rf_addr_first", {27'd0, rf_addr}, 32'd1);
    beats = 0;
    ready_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (halted) break;
      if (cmd_if.cmd_ready) ready_bad++;
      if (dump_valid) begin
        beats++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("dump_addr", {27'd0, dump_addr}, {27'd0, e.addr});
          check("dump_data", dump_data, e.data);
        end
      end
      tick();
    end
    check("dump_beats", 32'(beats), 32'd31);
    check("dump_ready_busy", 32'(ready_bad), 32'd0);
    check("dump_queue_empty", 32'(exp_q.size()), 32'd0);
    check("dump_end_halted", {31'd0, halted}, 32'd1);
    check("dump_cause_kept", {30'd0, halt_cause}, 32'd2);
    check("dump_rf_addr_end", {27'd0, rf_addr}, 32'd0);
    check("dump_valid_end", {31'd0, dump_valid}, 32'd0);

    // Ignored command while running
    load_pc(32'h100);
    send_cmd(OP_RUN, 32'h0);
    check("err_idle", {31'd0, cmd_if.cmd_err}, 32'd0);
    send_cmd(OP_STEP, 32'd3);
    check("err_pulse", {31'd0, cmd_if.cmd_err}, 32'd1);
    check("err_still_run", {31'd0, halted}, 32'd0);
    check("err_core_en", {31'd0, core_en}, 32'd1);
    tick();
    check("err_one_cycle", {31'd0, cmd_if.cmd_err}, 32'd0);
    send_cmd(OP_HALT, 32'h0);
    check("err_retired", {16'd0, retired_cnt}, 32'd8);
    check("err_pc", core_pc, 32'h10C);

    // HALT together with breakpoint match -> BKPT
    b = core_pc + 32'd8;
    send_cmd(OP_SET_BKPT, b);
    send_cmd(OP_RUN, 32'h0);
    for (int k = 0; k < 10; k++) begin
      if (core_pc == b) break;
      tick();
    end
    check("sim_pc_reach", core_pc, b);
    check("sim_core_en", {31'd0, core_en}, 32'd0);
    send_cmd(OP_HALT, 32'h0);
    check("sim_halted", {31'd0, halted}, 32'd1);
    check("sim_cause", {30'd0, halt_cause}, 32'd3);
    check("sim_retired", {16'd0, retired_cnt}, 32'd10);

    // HALT together with the final step -> HOST
    send_cmd(OP_STEP, 32'd2);
    tick();
    check("hf_core_en", {31'd0, core_en}, 32'd1);
    send_cmd(OP_HALT, 32'h0);
    check("hf_cause", {30'd0, halt_cause}, 32'd1);
    check("hf_retired", {16'd0, retired_cnt}, 32'd12);
    check("hf_pc", core_pc, b + 32'd8);

    // Breakpoint together with the final step -> BKPT
    send_cmd(OP_SET_BKPT, b + 32'd16);
    send_cmd(OP_STEP, 32'd3);
    wait_halted("bf_halt", 10);
    check("bf_cause", {30'd0, halt_cause}, 32'd3);
    check("bf_pc", core_pc, b + 32'd16);
    check("bf_retired", {16'd0, retired_cnt}, 32'd14);

    // Reset on the 12th dump beat
    for (int i = 1; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: regs[i]});
    send_cmd(OP_DUMP, 32'h0);
    beats = 0;
    for (int k = 0; k < 40; k++) begin
      if (dump_valid) begin
        beats++;
        e = exp_q.pop_front();
        check("rdump_addr", {27'd0, dump_addr}, {27'd0, e.addr});
      end
      if (beats == 12) break;
      tick();
    end
    check("rdump_reach12", 32'(beats), 32'd12);
    rst = 1'b0;
    #1;
    check("rdump_valid_drop", {31'd0, dump_valid}, 32'd0);
    check("rdump_halted", {31'd0, halted}, 32'd1);
    check("rdump_cause", {30'd0, halt_cause}, 32'd0);
    check("rdump_retired", {16'd0, retired_cnt}, 32'd0);
    check("rdump_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("rdump_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();

    // Breakpoint must be gone after reset
    load_pc(b + 32'd12);
    send_cmd(OP_RUN, 32'h0);
    tick();
    check("bkpt_cleared_pc", core_pc, b + 32'd16);
    check("bkpt_cleared_en", {31'd0, core_en}, 32'd1);
    send_cmd(OP_HALT, 32'h0);
    check("bkpt_cleared_retired", {16'd0, retired_cnt}, 32'd2);
    check("bkpt_cleared_cause", {30'd0, halt_cause}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
